// File: rtl/wrnic_irq_pkg.sv
// Shared constants and types for the WR-NIC interrupt vectorizer.
package wrnic_irq_pkg;

    localparam int c_max_irqs = 32;

    localparam logic [2:0] c_CTL  = 3'd0;
    localparam logic [2:0] c_IER  = 3'd1;
    localparam logic [2:0] c_IDR  = 3'd2;
    localparam logic [2:0] c_IMR  = 3'd3;
    localparam logic [2:0] c_VAR  = 3'd4;
    localparam logic [2:0] c_EOIR = 3'd5;
    localparam logic [2:0] c_SWIR = 3'd6;
    localparam logic [2:0] c_RISR = 3'd7;

    localparam int c_CTL_EN  = 0;
    localparam int c_CTL_POL = 1;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLDOFF
    } t_vic_state;

endpackage

// File: rtl/wrnic_prio_encoder.sv
// Fixed-priority encoder: index of the lowest set request bit plus an any-set flag.
module wrnic_prio_encoder #(
    parameter int g_width = 8
) (
    input  logic [g_width-1:0] req,
    output logic [4:0]         idx,
    output logic               any
);

    // Scan from the top down so the lowest set bit wins the last assignment.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = g_width - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 5'(i);
            end
        end
    end

endmodule

// File: rtl/wrnic_irq_vectorizer.sv
// Shares one host interrupt line between several edge-triggered sources:
// latches and masks source edges, serves one source at a time by fixed
// priority, holds the line until EOI and then enforces a holdoff gap.
module wrnic_irq_vectorizer
    import wrnic_irq_pkg::*;
#(
    parameter int g_num_irqs       = 8,
    parameter int g_holdoff_cycles = 64
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [2:0]            wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [g_num_irqs-1:0] irq_i,
    output logic                  irq_master_o,
    output logic [4:0]            vector_o,
    output logic                  vector_valid_o
);

    t_vic_state state, state_next;
    logic [15:0] hold_cnt, hold_cnt_next;
    logic [4:0]  cur_id, cur_id_next;
    logic        ctl_en, ctl_pol;

    logic [g_num_irqs-1:0] mask, pending, irq_prev;
    logic [g_num_irqs-1:0] set_bits, clr_bits, pending_next, sel_req;
    logic [c_max_irqs-1:0] mask_rd, pending_rd;
    logic [4:0]  sel_id;
    logic        sel_any;
    logic        wb_req, wb_wr, eoi;
    logic [31:0] rd_data;
    logic        unused_bits;

    // Byte selects are ignored and only the low source bits of write data matter.
    assign unused_bits = ^{wb_sel_i, wb_dat_i};

    // A new request starts in the cycle before ack; writes commit on the ack cycle.
    assign wb_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wb_wr  = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i;
    assign eoi    = wb_wr && (wb_adr_i == c_EOIR) && (state == ASSERT);

    assign sel_req    = pending & mask;
    assign mask_rd    = c_max_irqs'(mask);
    assign pending_rd = c_max_irqs'(pending);

    wrnic_prio_encoder #(
        .g_width (g_num_irqs)
    ) u_prio (
        .req (sel_req),
        .idx (sel_id),
        .any (sel_any)
    );

    // Register read multiplexer; unused bits and write-only registers read 0.
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            c_CTL: begin
                rd_data[c_CTL_EN]  = ctl_en;
                rd_data[c_CTL_POL] = ctl_pol;
            end
            c_IMR:   rd_data = mask_rd;
            c_VAR:   rd_data = {vector_valid_o, 26'd0, vector_o};
            c_RISR:  rd_data = pending_rd;
            default: rd_data = '0;
        endcase
    end

    // Single-cycle ack pulse with read data captured alongside it.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= wb_req ? rd_data : '0;
        end
    end

    // Control and mask registers, updated on the write ack cycle.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            ctl_en  <= 1'b0;
            ctl_pol <= 1'b0;
            mask    <= '0;
        end else if (wb_wr) begin
            case (wb_adr_i)
                c_CTL: begin
                    ctl_en  <= wb_dat_i[c_CTL_EN];
                    ctl_pol <= wb_dat_i[c_CTL_POL];
                end
                c_IER:   mask <= mask | wb_dat_i[g_num_irqs-1:0];
                c_IDR:   mask <= mask & ~wb_dat_i[g_num_irqs-1:0];
                default: mask <= mask;
            endcase
        end
    end

    // Pending update: rising edges and software sets override an EOI clear.
    always_comb begin
        set_bits = irq_i & ~irq_prev;
        if (wb_wr && (wb_adr_i == c_SWIR)) begin
            set_bits = set_bits | wb_dat_i[g_num_irqs-1:0];
        end
        clr_bits = '0;
        for (int i = 0; i < g_num_irqs; i++) begin
            if (eoi && (cur_id == 5'(i))) begin
                clr_bits[i] = 1'b1;
            end
        end
        pending_next = (pending & ~clr_bits) | set_bits;
    end

    // Source history for edge detection and the pending register.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irq_i;
            pending  <= pending_next;
        end
    end

    // Sequencer state, holdoff counter and the ID being served.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state    <= IDLE;
            hold_cnt <= '0;
            cur_id   <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            cur_id   <= cur_id_next;
        end
    end

    // Next-state logic and host-facing outputs.
    always_comb begin
        state_next     = state;
        hold_cnt_next  = hold_cnt;
        cur_id_next    = cur_id;
        irq_master_o   = ~ctl_pol;
        vector_valid_o = 1'b0;
        vector_o       = '0;
        case (state)
            IDLE: begin
                if (ctl_en && sel_any) begin
                    cur_id_next = sel_id;
                    state_next  = ASSERT;
                end
            end
            ASSERT: begin
                irq_master_o   = ctl_pol;
                vector_valid_o = 1'b1;
                vector_o       = cur_id;
                if (!ctl_en) begin
                    state_next = IDLE;
                end else if (eoi) begin
                    hold_cnt_next = 16'(g_holdoff_cycles);
                    state_next    = (g_holdoff_cycles == 0) ? IDLE : HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!ctl_en) begin
                    hold_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt - 16'd1;
                    if (hold_cnt <= 16'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wrnic_irq_vectorizer.sv
// Testbench for wrnic_irq_vectorizer: register vector table, directed
// multi-cycle sequences and a randomized service-order check.
module tb_wrnic_irq_vectorizer;
    import wrnic_irq_pkg::*;

    localparam int c_n    = 8;
    localparam int c_hold = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             cyc, stb, we;
    logic [2:0]       adr;
    logic [3:0]       sel;
    logic [31:0]      dat_w, dat_r;
    logic             ack;
    logic [c_n-1:0]   irq;
    logic             line;
    logic [4:0]       vec;
    logic             valid;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [2:0]  adr;
        logic [31:0] wdata;
        logic [31:0] rexp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    wrnic_irq_vectorizer #(
        .g_num_irqs       (c_n),
        .g_holdoff_cycles (c_hold)
    ) dut (
        .clk_sys_i      (clk),
        .rst_sys_i      (rst),
        .wb_cyc_i       (cyc),
        .wb_stb_i       (stb),
        .wb_we_i        (we),
        .wb_adr_i       (adr),
        .wb_sel_i       (sel),
        .wb_dat_i       (dat_w),
        .wb_dat_o       (dat_r),
        .wb_ack_o       (ack),
        .irq_i          (irq),
        .irq_master_o   (line),
        .vector_o       (vec),
        .vector_valid_o (valid)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One Wishbone access; optionally raises irq bits during the ack cycle.
    task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [31:0] d,
                                 input logic [c_n-1:0] irq_at_ack, output logic [31:0] rd);
        int n;
        bit got;
        got = 1'b0;
        n   = 0;
        rd  = '0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = 4'hF;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (ack) begin
                got = 1'b1;
                rd  = dat_r;
            end
        end
        checkOutput("wb_ack_latency", n, 1);
        irq = irq | irq_at_ack;
        @(posedge clk); #1;
        irq = irq & ~irq_at_ack;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        checkOutput("wb_ack_pulse", {31'd0, ack}, 0);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] junk;
        applyStimulus(1'b1, a, d, '0, junk);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] rd);
        applyStimulus(1'b0, a, 32'h0, '0, rd);
    endtask

    task automatic pulse(input logic [c_n-1:0] b);
        irq = irq | b;
        @(posedge clk); #1;
        irq = irq & ~b;
    endtask

    // Waits (bounded) for the host line to reach a level; n counts cycles waited.
    task automatic wait_line(input logic lvl, input int limit, output int n);
        n = 0;
        while (line !== lvl && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0; irq = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic add_vec(input logic w, input logic [2:0] a, input logic [31:0] d,
                           input logic [31:0] e, input string nm);
        vec_t v;
        v.we = w; v.adr = a; v.wdata = d; v.rexp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    // Reference: the source served next is the lowest-numbered pending, unmasked one.
    function automatic int lowest_set(input logic [c_n-1:0] x);
        for (int i = 0; i < c_n; i++) begin
            if (x[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        logic [31:0]    rd;
        int             n;
        logic           pol;
        logic [c_n-1:0] pend_m, mask_m, edg, swb;
        logic [31:0]    junk;
        int             exp_id;

        rst = 1'b1;
        do_reset();

        checkOutput("rst_line", {31'd0, line}, 1);
        checkOutput("rst_valid", {31'd0, valid}, 0);
        checkOutput("rst_vector", {27'd0, vec}, 0);
        checkOutput("rst_ack", {31'd0, ack}, 0);
        checkOutput("rst_dat", dat_r, 0);

        add_vec(0, c_CTL,  0, 32'h0, "rst_ctl");
        add_vec(0, c_IER,  0, 32'h0, "rst_ier");
        add_vec(0, c_IDR,  0, 32'h0, "rst_idr");
        add_vec(0, c_IMR,  0, 32'h0, "rst_imr");
        add_vec(0, c_VAR,  0, 32'h0, "rst_var");
        add_vec(0, c_EOIR, 0, 32'h0, "rst_eoir");
        add_vec(0, c_SWIR, 0, 32'h0, "rst_swir");
        add_vec(0, c_RISR, 0, 32'h0, "rst_risr");
        add_vec(1, c_IER,  32'hFFFFFF05, 32'h0, "w_ier");
        add_vec(0, c_IMR,  0, 32'h05, "imr_high_bits_zero");
        add_vec(1, c_IDR,  32'h00000004, 32'h0, "w_idr");
        add_vec(0, c_IMR,  0, 32'h01, "imr_after_idr");
        add_vec(1, c_CTL,  32'hFFFFFFFE, 32'h0, "w_ctl");
        add_vec(0, c_CTL,  0, 32'h02, "ctl_pol_only");
        add_vec(1, c_SWIR, 32'h00000110, 32'h0, "w_swir");
        add_vec(0, c_RISR, 0, 32'h10, "risr_swir");
        add_vec(1, c_EOIR, 32'h0, 32'h0, "w_eoir_idle");
        add_vec(0, c_RISR, 0, 32'h10, "eoi_outside_assert");
        add_vec(1, c_CTL,  32'h0, 32'h0, "w_ctl_zero");
        add_vec(0, c_CTL,  0, 32'h0, "ctl_zero");

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].we, tbl[i].adr, tbl[i].wdata, '0, rd);
            if (!tbl[i].we) checkOutput(tbl[i].name, rd, tbl[i].rexp);
        end

        do_reset();

        // Single source, active-high: line within 3 cycles of the edge.
        wb_write(c_IER, 32'h1);
        wb_write(c_CTL, 32'h3);
        pulse(8'h01);
        wait_line(1'b1, 2, n);
        checkOutput("tp1_line", {31'd0, line}, 1);
        wb_read(c_VAR, rd);
        checkOutput("tp1_var", rd, 32'h80000000);
        wb_write(c_EOIR, 32'h0);
        repeat (c_hold + 4) @(posedge clk);
        #1;

        // Simultaneous edges: 2 first; 64 holdoff cycles plus one arbitration cycle, then 5.
        wb_write(c_IDR, 32'hFF);
        wb_write(c_IER, 32'h24);
        pulse(8'h24);
        wait_line(1'b1, 4, n);
        wb_read(c_VAR, rd);
        checkOutput("tp2_var_first", rd, 32'h80000002);
        wb_write(c_EOIR, 32'h0);
        wait_line(1'b1, 200, n);
        checkOutput("tp2_holdoff_len", n, 65);
        wb_read(c_VAR, rd);
        checkOutput("tp2_var_second", rd, 32'h80000005);
        wb_write(c_EOIR, 32'h0);
        repeat (c_hold + 4) @(posedge clk);
        #1;

        // Software-triggered interrupt, then EOI clears it and the line stays idle.
        wb_write(c_IER, 32'h1);
        wb_write(c_SWIR, 32'h1);
        wait_line(1'b1, 4, n);
        checkOutput("tp3_swir_line", {31'd0, line}, 1);
        wb_write(c_EOIR, 32'h0);
        wait_line(1'b1, 64, n);
        checkOutput("tp3_line_idle", n, 64);
        wb_read(c_RISR, rd);
        checkOutput("tp3_risr", rd, 32'h0);

        // Active-low line; clearing EN releases it the next cycle, pending kept.
        wb_write(c_CTL, 32'h1);
        checkOutput("tp4_idle_level", {31'd0, line}, 1);
        wb_write(c_IER, 32'h8);
        pulse(8'h08);
        wait_line(1'b0, 4, n);
        checkOutput("tp4_line_active", {31'd0, line}, 0);
        wb_write(c_CTL, 32'h0);
        checkOutput("tp4_still_assert", {31'd0, line}, 0);
        @(posedge clk); #1;
        checkOutput("tp4_en_cleared", {31'd0, line}, 1);
        wb_read(c_RISR, rd);
        checkOutput("tp4_risr", rd, 32'h8);

        // New edge on the served source in the EOI cycle keeps it pending.
        wb_write(c_IDR, 32'hFF);
        wb_write(c_IER, 32'h2);
        wb_write(c_CTL, 32'h1);
        pulse(8'h02);
        wait_line(1'b0, 4, n);
        wb_read(c_VAR, rd);
        checkOutput("tp5_var", rd, 32'h80000001);
        applyStimulus(1'b1, c_EOIR, 32'h0, 8'h02, rd);
        wb_read(c_RISR, rd);
        checkOutput("tp5_risr", rd, 32'h0A);
        wait_line(1'b0, 200, n);
        checkOutput("tp5_reassert", {31'd0, line}, 0);
        wb_read(c_VAR, rd);
        checkOutput("tp5_var_again", rd, 32'h80000001);

        // Asynchronous reset in the middle of ASSERT.
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_line", {31'd0, line}, 1);
        checkOutput("arst_valid", {31'd0, valid}, 0);
        checkOutput("arst_vector", {27'd0, vec}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), rd);
            checkOutput("arst_reg", rd, 32'h0);
        end

        // Randomized rounds against the service-order model.
        pend_m = '0;
        for (int it = 0; it < 12; it++) begin
            pol  = 1'($urandom_range(0, 1));
            wb_write(c_CTL, {30'd0, pol, 1'b0});
            mask_m = c_n'($urandom_range(0, 255));
            junk   = $urandom;
            wb_write(c_IDR, 32'hFFFFFFFF);
            wb_write(c_IER, {junk[31:8], mask_m});
            edg = c_n'($urandom_range(0, 255));
            swb = (it % 3 == 0) ? c_n'($urandom_range(0, 255)) : '0;
            if (swb != '0) wb_write(c_SWIR, {24'd0, swb});
            pulse(edg);
            pend_m = pend_m | edg | swb;
            checkOutput("rnd_idle_line", {31'd0, line}, {31'd0, ~pol});
            wb_write(c_CTL, {30'd0, pol, 1'b1});
            while ((pend_m & mask_m) != '0) begin
                exp_id = lowest_set(pend_m & mask_m);
                wait_line(pol, 200, n);
                checkOutput("rnd_valid", {31'd0, valid}, 1);
                checkOutput("rnd_vector", {27'd0, vec}, exp_id);
                wb_write(c_EOIR, $urandom);
                pend_m[exp_id] = 1'b0;
            end
            repeat (c_hold + 4) @(posedge clk);
            #1;
            checkOutput("rnd_quiet", {31'd0, valid}, 0);
            wb_read(c_RISR, rd);
            checkOutput("rnd_risr", rd, {24'd0, pend_m});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
